// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Multi-nibble add/subtract sequencer that reuses one 4-bit
//               ripple-carry adder, LSB nibble first, with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder_4bit (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   logic [4:0] w_c;

   assign w_c[0] = cin_i;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_bit
         assign sum_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
         assign w_c[i + 1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
      end
   endgenerate

   assign cout_o = w_c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [4*NIBBLES-1:0] in_a_i,
   input  logic [4*NIBBLES-1:0] in_b_i,
   input  logic                 in_cin_i,
   input  logic                 in_sub_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [4*NIBBLES-1:0] out_sum_o,
   output logic                 out_cout_o,
   output logic                 out_ovf_o
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_sum_nib;
   logic             w_cout;

   always_comb begin
      w_a_nib = '0;
      w_b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_a_nib = a_q[4*i +: 4];
            w_b_nib = b_q[4*i +: 4];
         end
      end
   end

   ripple_carry_adder_4bit u_adder (
      .a_i    (w_a_nib),
      .b_i    (w_b_nib),
      .cin_i  (carry_q),
      .sum_o  (w_sum_nib),
      .cout_o (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
               a_d     = in_a_i;
               b_d     = in_sub_i ? ~in_b_i : in_b_i;
               carry_d = in_sub_i ? 1'b1 : in_cin_i;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[4*i +: 4] = w_sum_nib;
               end
            end
            carry_d = w_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == C_LAST_IDX) begin
               cout_d  = w_cout;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (w_sum_nib[3] != a_q[W-1]);
               idx_d   = '0;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign out_sum_o   = sum_q;
   assign out_cout_o  = cout_q;
   assign out_ovf_o   = ovf_q;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Self-checking bench: vector table, corner sequences and
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder_ctrl;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t tbl[6];

   nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_a_i      (in_a),
      .in_b_i      (in_b),
      .in_cin_i    (in_cin),
      .in_sub_i    (in_sub),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_cout_o  (out_cout),
      .out_ovf_o   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        output logic [W-1:0] s, output logic co, output logic ov);
      int sa;
      int sb;
      int r;
      int ua;
      int ub;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      if (sub) begin
         r  = sa - sb;
         co = (ua >= ub);
      end else begin
         r  = sa + sb + int'(cin);
         co = ((ua + ub + int'(cin)) >= (1 << W));
      end
      s  = r[W-1:0];
      ov = (r > ((1 << (W - 1)) - 1)) || (r < -(1 << (W - 1)));
   endtask

   // Issues one request from IDLE and waits for out_valid, checking latency.
   task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
      int cyc;
      chk({nm, " in_ready before accept"}, 32'(in_ready), 32'd1);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid === 1'b1 || cyc > 20) break;
         chk({nm, " in_ready during RUN"}, 32'(in_ready), 32'd0);
      end
      chk({nm, " latency"}, 32'(cyc), 32'(NIB));
      chk({nm, " in_ready in DONE"}, 32'(in_ready), 32'd0);
   endtask

   task automatic check_result(input string nm, input logic [W-1:0] s,
                               input logic co, input logic ov);
      chk({nm, " sum"}, 32'(out_sum), 32'(s));
      chk({nm, " cout"}, 32'(out_cout), 32'(co));
      chk({nm, " ovf"}, 32'(out_ovf), 32'(ov));
   endtask

   task automatic consume(input string nm);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, " out_valid after consume"}, 32'(out_valid), 32'd0);
      chk({nm, " in_ready after consume"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string nm);
      chk({nm, " out_valid"}, 32'(out_valid), 32'd0);
      chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
      chk({nm, " out_sum"}, 32'(out_sum), 32'd0);
      chk({nm, " out_cout"}, 32'(out_cout), 32'd0);
      chk({nm, " out_ovf"}, 32'(out_ovf), 32'd0);
   endtask

   initial begin
      logic [W-1:0] es;
      logic         ec;
      logic         eo;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;

      n_cmp  = 0;
      n_fail = 0;

      tbl[0] = '{a: 16'h1234, b: 16'h0F0F, cin: 1'b0, sub: 1'b0, sum: 16'h2143, cout: 1'b0, ovf: 1'b0};
      tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h0000, cout: 1'b1, ovf: 1'b0};
      tbl[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, sub: 1'b0, sum: 16'h8000, cout: 1'b0, ovf: 1'b1};
      tbl[3] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, sub: 1'b0, sum: 16'hFFFF, cout: 1'b1, ovf: 1'b0};
      tbl[4] = '{a: 16'h0005, b: 16'h0007, cin: 1'b1, sub: 1'b1, sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
      tbl[5] = '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("power-on reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("idle after reset out_valid", 32'(out_valid), 32'd0);
      end

      for (int i = 0; i < 6; i++) begin
         run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
         check_result($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
         consume($sformatf("vec%0d", i));
      end

      // Backpressure: result held, new request ignored while in DONE.
      run_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
      in_a     = 16'hAAAA;
      in_b     = 16'h5555;
      in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp out_valid held", 32'(out_valid), 32'd1);
         chk("bp in_ready low", 32'(in_ready), 32'd0);
         chk("bp sum held", 32'(out_sum), 32'h3333);
      end
      in_valid = 1'b0;
      consume("bp");
      run_op("bp next", 16'h0100, 16'h0200, 1'b0, 1'b0);
      check_result("bp next", 16'h0300, 1'b0, 1'b0);
      consume("bp next");

      // Asynchronous reset while sitting in DONE.
      run_op("rst done", 16'h00FF, 16'h0001, 1'b0, 1'b0);
      check_result("rst done", 16'h0100, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_values("reset in DONE");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("idle after DONE reset out_valid", 32'(out_valid), 32'd0);
      end

      // Asynchronous reset two cycles into RUN.
      in_a     = 16'hFFFF;
      in_b     = 16'hFFFF;
      in_cin   = 1'b1;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("reset mid-RUN");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after mid-RUN reset out_valid", 32'(out_valid), 32'd0);
      run_op("post reset", 16'h0001, 16'h0001, 1'b0, 1'b0);
      check_result("post reset", 16'h0002, 1'b0, 1'b0);
      consume("post reset");

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         if (i < 4) rb = ra;
         model(ra, rb, rc, rs, es, ec, eo);
         run_op($sformatf("rand%0d", i), ra, rb, rc, rs);
         check_result($sformatf("rand%0d a=%h b=%h cin=%0d sub=%0d", i, ra, rb, rc, rs), es, ec, eo);
         consume($sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a multi-nibble add or subtract by time-multiplexing one `ripple_carry_adder_4bit` instance, one nibble per clock, LSB nibble first. Carry is chained through a carry register. Operands enter through a valid/ready handshake and results leave through one. The block sits between a requesting unit and the shared 4-bit adder datapath, trading latency for area on wide operands.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES; legal range >= 1.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_cin` in 1: carry-in for add; ignored when `in_sub`=1.
- `in_sub` in 1: 1 = A−B (A + ~B + 1), 0 = A + B + cin.
- `out_valid` out 1: result valid; high only in DONE.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out W: result.
- `out_cout` out 1: carry out of MSB (for subtract, 1 = no borrow).
- `out_ovf` out 1: two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready` the block captures A, B_eff = `in_sub` ? ~B : B, and carry_reg = `in_sub` ? 1 : `in_cin`.
  - Nibble index idx is set to 0, then the state moves to RUN.
- RUN:
  - Adder inputs are A[4idx+3:4idx], B_eff[4idx+3:4idx] and carry_reg.
  - On each edge the adder Sum is written into result nibble idx, carry_reg takes the adder Cout, and idx increments.
  - On the edge where idx = NIBBLES−1: `out_cout` takes the final Cout, `out_ovf` = (A[W−1]==B_eff[W−1]) && (Sum_msb != A[W−1]), and the state moves to DONE.
- DONE:
  - `out_valid`=1.
  - `out_sum`, `out_cout` and `out_ovf` are held stable.
  - On `out_valid`&`out_ready` the state moves to IDLE.
- `in_valid` outside IDLE is ignored; the request is not queued.
- `out_sum` is the result register. It changes nibble by nibble during RUN and is only meaningful while `out_valid`=1. It retains its last value in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- NIBBLES=1: RUN lasts one cycle, with the same flow.

## Timing
- Reset (`rst_n` low, asynchronous at any time, including mid-RUN or in DONE):
  - State becomes IDLE and idx becomes 0.
  - `out_sum`=0, `out_cout`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1.
  - Any in-flight operation is discarded.
- Accept happens at edge k. RUN occupies edges k+1 … k+NIBBLES. `out_valid` rises after edge k+NIBBLES, i.e. the latency is NIBBLES cycles from accept.
- With `out_ready` tied high, `out_valid` is high for exactly one cycle and `in_ready` returns the cycle after. Sustained throughput is one operation per NIBBLES+2 cycles.
- Backpressure: DONE persists indefinitely while `out_ready`=0 and the result stays unchanged.
- Wrap-around: the carry out of the MSB nibble goes only to `out_cout`. The sum is modulo 2^W.

## Test plan
- **Reset:** assert `rst_n`=0 mid-sim → `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0, `in_ready`=1. Release reset → the block stays IDLE with no spurious `out_valid`.
- **Basic add and latency:** NIBBLES=4, A=0x1234, B=0x0F0F, cin=0 → `out_sum`=0x2143, cout=0, ovf=0. `out_valid` rises exactly 4 cycles after the accept edge, and `in_ready`=0 throughout RUN/DONE.
- **Carry/overflow edges:**
  - 0xFFFF+0x0001, cin=0 → 0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
  - 0xFFFF+0xFFFF, cin=1 → 0xFFFF, cout=1, ovf=0.
- **Subtract:**
  - 0x0005−0x0007 with `in_cin`=1 (must be ignored) → 0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while driving a new `in_valid` → result held, `in_ready`=0, and the new request is not taken. Raise `out_ready` → `in_ready` is back next cycle, and the next request completes correctly.
- **Reset mid-RUN:** pull `rst_n` low 2 cycles after accept → outputs are the reset values immediately. After release, 0x0001+0x0001 gives 0x0002 with no residue from the aborted operation.
